shift_reg_engine: RTL and testbench

//   Parametrised load/shift register with a multi-bit step, four shift modes and an

---
 rtl/shift_reg_engine_if.sv | 37 +++
 rtl/shift_reg_engine.sv | 139 +++++++++++++
 tb/tb_shift_reg_engine.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_engine_if.sv
// Bundle of control, data and status signals for the shift register engine.
// Pure wiring: no storage and no added latency.
// No backpressure: start/step_en issued while busy are ignored by the engine.
interface shift_reg_engine_if #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 4
);

  // Commands and operands into the engine
  logic             load_en;
  logic [WIDTH-1:0] d;
  logic [1:0]       mode;
  logic             step_en;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [STEP-1:0]  shift_in;

  // Register contents and burst status out of the engine
  logic [WIDTH-1:0] q;
  logic [STEP-1:0]  shift_out;
  logic             busy;
  logic             done;

  // Side that issues commands (a controller or a testbench)
  modport master (
    output load_en, d, mode, step_en, start, count, shift_in,
    input  q, shift_out, busy, done
  );

  // Side that implements the register (the engine)
  modport slave (
    input  load_en, d, mode, step_en, start, count, shift_in,
    output q, shift_out, busy, done
  );

endinterface

// File: rtl/shift_reg_engine.sv
// Load/shift register with STEP-bit shifts (LSR/ASR/LSL/ROR) and an autonomous burst engine.
// Latency: a load or shift is visible on q one cycle after its edge; done pulses the cycle after the last burst shift.
// Backpressure: start/step_en are ignored while busy; load_en always wins and aborts a running burst.
module shift_reg_engine #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 4
) (
  input logic           clk,
  input logic           rst,
  shift_reg_engine_if.slave bus
);

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       run_mode;   // mode captured at start, held for the whole burst
  logic [CNT_W-1:0] remaining;  // shifts still to perform, >=1 whenever in RUN
  logic [WIDTH-1:0] q_reg;
  logic [STEP-1:0]  shift_out_reg;
  logic             done_reg;

  logic [1:0]       op_mode;
  logic [WIDTH-1:0] q_next;
  logic [STEP-1:0]  shift_out_next;

  // A burst uses its latched mode; a single step uses the live mode input.
  always_comb begin
    op_mode = bus.mode;
    if (state == RUN) begin
      op_mode = run_mode;
    end
  end

  // Result of one STEP-bit shift of the current register in the selected mode.
  always_comb begin
    q_next         = q_reg;
    shift_out_next = shift_out_reg;
    case (op_mode)
      MODE_LSR: begin
        q_next         = {bus.shift_in, q_reg[WIDTH-1:STEP]};
        shift_out_next = q_reg[STEP-1:0];
      end
      MODE_ASR: begin
        q_next         = {{STEP{q_reg[WIDTH-1]}}, q_reg[WIDTH-1:STEP]};
        shift_out_next = q_reg[STEP-1:0];
      end
      MODE_LSL: begin
        q_next         = {q_reg[WIDTH-1-STEP:0], bus.shift_in};
        shift_out_next = q_reg[WIDTH-1:WIDTH-STEP];
      end
      MODE_ROR: begin
        q_next         = {q_reg[STEP-1:0], q_reg[WIDTH-1:STEP]};
        shift_out_next = q_reg[STEP-1:0];
      end
      default: begin
        q_next         = q_reg;
        shift_out_next = shift_out_reg;
      end
    endcase
  end

  // Control FSM and datapath registers; done is a single-cycle pulse cleared every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      run_mode      <= MODE_LSR;
      remaining     <= '0;
      q_reg         <= '0;
      shift_out_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_en) begin
            q_reg <= bus.d;
          end else if (bus.start) begin
            // A zero-length burst completes immediately without shifting.
            if (bus.count != '0) begin
              run_mode  <= bus.mode;
              remaining <= bus.count;
              state     <= RUN;
            end else begin
              done_reg <= 1'b1;
            end
          end else if (bus.step_en) begin
            q_reg         <= q_next;
            shift_out_reg <= shift_out_next;
          end
        end
        RUN: begin
          if (bus.load_en) begin
            // Abort: new data replaces the burst and no completion is signalled.
            q_reg     <= bus.d;
            remaining <= '0;
            state     <= IDLE;
          end else begin
            q_reg         <= q_next;
            shift_out_reg <= shift_out_next;
            remaining     <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
              state    <= IDLE;
              done_reg <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
        end
      endcase
    end
  end

  assign bus.q         = q_reg;
  assign bus.shift_out = shift_out_reg;
  assign bus.busy      = (state == RUN);
  assign bus.done      = done_reg;

  // Completion is only reported once the engine is back in IDLE.
  a_done_not_busy : assert property (@(posedge clk) disable iff (rst)
    !(bus.done && bus.busy));

  // A running burst always has at least one shift left.
  a_run_has_work : assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> (remaining != '0));

endmodule

// File: tb/tb_shift_reg_engine.sv
// Self-checking bench for shift_reg_engine: STEP=1 and STEP=2 instances, WIDTH=8.
// Expected register/status values are pushed to a scoreboard when stimulus is issued
// and popped one entry per clock as the DUT produces them.
module tb_shift_reg_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_reg_engine_if #(.WIDTH(8), .STEP(1), .CNT_W(4)) b1 ();
  shift_reg_engine_if #(.WIDTH(8), .STEP(2), .CNT_W(4)) b2 ();

  shift_reg_engine #(.WIDTH(8), .STEP(1), .CNT_W(4)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  shift_reg_engine #(.WIDTH(8), .STEP(2), .CNT_W(4)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  typedef struct {
    logic [7:0] q;
    logic [1:0] so;
    logic       busy;
    logic       done;
    bit         chk_so;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   sel      = 1'b0;  // 0 -> STEP=1 instance, 1 -> STEP=2 instance

  logic [7:0] obs_q;
  logic [1:0] obs_so;
  logic       obs_busy;
  logic       obs_done;

  // Outputs of whichever instance the current test exercises
  always_comb begin
    obs_q    = sel ? b2.q : b1.q;
    obs_so   = sel ? b2.shift_out : {1'b0, b1.shift_out};
    obs_busy = sel ? b2.busy : b1.busy;
    obs_done = sel ? b2.done : b1.done;
  end

  // Reference shift written arithmetically; returns {shift_out, q}
  function automatic logic [9:0] ref_shift(input logic [7:0] q, input logic [1:0] m,
                                           input logic [1:0] si, input int s);
    logic [7:0] mask, nq, so;
    mask = 8'((1 << s) - 1);
    case (m)
      2'b00: begin nq = (q >> s) | (8'(si) << (8 - s)); so = q & mask; end
      2'b01: begin nq = 8'($signed(q) >>> s);           so = q & mask; end
      2'b10: begin nq = 8'(q << s) | 8'(si);            so = 8'(q >> (8 - s)); end
      default: begin nq = 8'(q >> s) | 8'(q << (8 - s)); so = q & mask; end
    endcase
    return {so[1:0], nq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the selected instance; the other one is held idle
  task automatic set_in(input logic le, input logic [7:0] dd, input logic [1:0] m,
                        input logic se, input logic st, input logic [3:0] cnt,
                        input logic [1:0] si);
    b1.load_en = !sel && le;  b2.load_en = sel && le;
    b1.d       = sel ? 8'h00 : dd;  b2.d = sel ? dd : 8'h00;
    b1.mode    = sel ? 2'b00 : m;   b2.mode = sel ? m : 2'b00;
    b1.step_en = !sel && se;  b2.step_en = sel && se;
    b1.start   = !sel && st;  b2.start   = sel && st;
    b1.count   = sel ? 4'd0 : cnt;  b2.count = sel ? cnt : 4'd0;
    b1.shift_in = sel ? 1'b0 : si[0];
    b2.shift_in = sel ? si : 2'b00;
  endtask

  // Expected state after the start edge, each burst shift, and optionally one idle edge
  task automatic push_burst(input logic [7:0] q0, input logic [1:0] m, input logic [1:0] si,
                            input int n, input int s, input bit tail, output logic [7:0] qf);
    exp_t       x;
    logic [9:0] r;
    logic [7:0] qv;
    qv = q0;
    x.q = q0; x.so = 2'b00; x.busy = 1'b1; x.done = 1'b0; x.chk_so = 1'b0;
    sb.push_back(x);
    for (int i = 1; i <= n; i++) begin
      r = ref_shift(qv, m, si, s);
      qv = r[7:0];
      x.q = qv; x.so = r[9:8]; x.busy = (i < n); x.done = (i == n); x.chk_so = 1'b1;
      sb.push_back(x);
    end
    if (tail) begin
      x.busy = 1'b0; x.done = 1'b0;
      sb.push_back(x);
    end
    qf = qv;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      b1.load_en = 1'($urandom); b1.d = 8'($urandom); b1.mode = 2'($urandom);
      b1.step_en = 1'b1; b1.start = 1'($urandom); b1.count = 4'($urandom); b1.shift_in = 1'($urandom);
      b2.load_en = 1'($urandom); b2.d = 8'($urandom); b2.mode = 2'($urandom);
      b2.step_en = 1'b1; b2.start = 1'b1; b2.count = 4'($urandom); b2.shift_in = 2'($urandom);
      tick();
    end
    n_checks++; if (b1.q !== 8'h00) $display("FAIL reset_q1 got %h want 00", b1.q); else n_pass++;
    n_checks++; if (b1.busy !== 1'b0 || b1.done !== 1'b0) $display("FAIL reset_stat1 got busy=%b done=%b want 0 0", b1.busy, b1.done); else n_pass++;
    n_checks++; if (b1.shift_out !== 1'b0) $display("FAIL reset_so1 got %b want 0", b1.shift_out); else n_pass++;
    n_checks++; if (b2.q !== 8'h00) $display("FAIL reset_q2 got %h want 00", b2.q); else n_pass++;
    n_checks++; if (b2.busy !== 1'b0 || b2.done !== 1'b0) $display("FAIL reset_stat2 got busy=%b done=%b want 0 0", b2.busy, b2.done); else n_pass++;
    n_checks++; if (b2.shift_out !== 2'b00) $display("FAIL reset_so2 got %b want 00", b2.shift_out); else n_pass++;
    sel = 1'b0; set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b00);
    sel = 1'b1; set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b00);
    rst = 1'b0;
    tick();
    n_checks++; if (b2.q !== 8'h00 || b2.busy !== 1'b0) $display("FAIL reset_release got q=%h busy=%b want 00 0", b2.q, b2.busy); else n_pass++;
  endtask

  task automatic test_lsr_step();
    logic [7:0] want [3];
    logic [7:0] qv;
    logic [9:0] r;
    exp_t       x;
    want[0] = 8'hD5; want[1] = 8'hEA; want[2] = 8'hF5;
    sel = 1'b0;
    set_in(1, 8'hAA, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    n_checks++; if (obs_q !== 8'hAA) $display("FAIL lsr_load got %h want aa", obs_q); else n_pass++;
    qv = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      r = ref_shift(qv, 2'b00, 2'b01, 1);
      qv = r[7:0];
      x.q = qv; x.so = r[9:8]; x.busy = 1'b0; x.done = 1'b0; x.chk_so = 1'b1;
      sb.push_back(x);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 8'h00, 2'b00, 1, 0, 4'd0, 2'b01);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs_q !== e.q || obs_so !== e.so || obs_busy !== e.busy || obs_done !== e.done)
        $display("FAIL lsr_step[%0d] got q=%h so=%b busy=%b done=%b want q=%h so=%b busy=%b done=%b",
                 i, obs_q, obs_so, obs_busy, obs_done, e.q, e.so, e.busy, e.done);
      else n_pass++;
      n_checks++; if (obs_q !== want[i]) $display("FAIL lsr_const[%0d] got %h want %h", i, obs_q, want[i]); else n_pass++;
    end
    set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    n_checks++; if (obs_q !== 8'hF5 || obs_done !== 1'b0) $display("FAIL lsr_hold got q=%h done=%b want f5 0", obs_q, obs_done); else n_pass++;
  endtask

  task automatic test_asr_burst();
    logic [7:0] qf;
    sel = 1'b1;
    set_in(1, 8'h96, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    push_burst(8'h96, 2'b01, 2'b00, 3, 2, 1'b1, qf);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) set_in(0, 8'h00, 2'b01, 0, 1, 4'd3, 2'b00);
      else        set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b00);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs_q !== e.q || obs_busy !== e.busy || obs_done !== e.done || (e.chk_so && obs_so !== e.so))
        $display("FAIL asr_burst[%0d] got q=%h so=%b busy=%b done=%b want q=%h so=%b busy=%b done=%b",
                 i, obs_q, obs_so, obs_busy, obs_done, e.q, e.so, e.busy, e.done);
      else n_pass++;
    end
    n_checks++; if (obs_q !== 8'hFE || obs_so !== 2'b01) $display("FAIL asr_final got q=%h so=%b want fe 01", obs_q, obs_so); else n_pass++;
  endtask

  task automatic test_ror_lsl();
    logic [7:0] qf;
    sel = 1'b1;
    set_in(1, 8'h81, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    push_burst(8'h81, 2'b11, 2'b00, 4, 2, 1'b1, qf);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_in(0, 8'h00, 2'b11, 0, 1, 4'd4, 2'b00);
      else        set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b00);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs_q !== e.q || obs_busy !== e.busy || obs_done !== e.done || (e.chk_so && obs_so !== e.so))
        $display("FAIL ror_burst[%0d] got q=%h so=%b busy=%b done=%b want q=%h so=%b busy=%b done=%b",
                 i, obs_q, obs_so, obs_busy, obs_done, e.q, e.so, e.busy, e.done);
      else n_pass++;
    end
    n_checks++; if (obs_q !== 8'h81) $display("FAIL ror_final got %h want 81", obs_q); else n_pass++;
    set_in(1, 8'h0F, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    push_burst(8'h0F, 2'b10, 2'b11, 2, 2, 1'b1, qf);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_in(0, 8'h00, 2'b10, 0, 1, 4'd2, 2'b11);
      else        set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b11);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs_q !== e.q || obs_busy !== e.busy || obs_done !== e.done || (e.chk_so && obs_so !== e.so))
        $display("FAIL lsl_burst[%0d] got q=%h so=%b busy=%b done=%b want q=%h so=%b busy=%b done=%b",
                 i, obs_q, obs_so, obs_busy, obs_done, e.q, e.so, e.busy, e.done);
      else n_pass++;
    end
    n_checks++; if (obs_q !== 8'hFF || obs_so !== 2'b00) $display("FAIL lsl_final got q=%h so=%b want ff 00", obs_q, obs_so); else n_pass++;
  endtask

  task automatic test_count_zero();
    sel = 1'b1;
    set_in(1, 8'h3C, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    set_in(0, 8'h00, 2'b00, 0, 1, 4'd0, 2'b11);
    tick();
    n_checks++; if (obs_q !== 8'h3C || obs_done !== 1'b1 || obs_busy !== 1'b0)
      $display("FAIL count0_pulse got q=%h done=%b busy=%b want 3c 1 0", obs_q, obs_done, obs_busy); else n_pass++;
    set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    n_checks++; if (obs_q !== 8'h3C || obs_done !== 1'b0 || obs_busy !== 1'b0)
      $display("FAIL count0_after got q=%h done=%b busy=%b want 3c 0 0", obs_q, obs_done, obs_busy); else n_pass++;
  endtask

  task automatic test_run_ignores();
    logic [7:0] qf;
    sel = 1'b1;
    set_in(1, 8'h96, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    push_burst(8'h96, 2'b01, 2'b00, 3, 2, 1'b1, qf);
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      set_in(0, 8'h00, 2'b01, 0, 1, 4'd3, 2'b00);
      else if (i <= 3) set_in(0, 8'h00, 2'b10, 1, 1, 4'd7, 2'b11);
      else             set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b00);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs_q !== e.q || obs_busy !== e.busy || obs_done !== e.done || (e.chk_so && obs_so !== e.so))
        $display("FAIL run_ignore[%0d] got q=%h so=%b busy=%b done=%b want q=%h so=%b busy=%b done=%b",
                 i, obs_q, obs_so, obs_busy, obs_done, e.q, e.so, e.busy, e.done);
      else n_pass++;
    end
    n_checks++; if (obs_q !== 8'hFE) $display("FAIL run_ignore_final got %h want fe", obs_q); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] qf, qf2;
    sel = 1'b1;
    set_in(1, 8'h81, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    push_burst(8'h81, 2'b11, 2'b00, 2, 2, 1'b0, qf);
    push_burst(qf, 2'b11, 2'b00, 2, 2, 1'b1, qf2);
    for (int i = 0; i < 7; i++) begin
      if (i == 0 || i == 3) set_in(0, 8'h00, 2'b11, 0, 1, 4'd2, 2'b00);
      else                  set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b00);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs_q !== e.q || obs_busy !== e.busy || obs_done !== e.done || (e.chk_so && obs_so !== e.so))
        $display("FAIL b2b[%0d] got q=%h so=%b busy=%b done=%b want q=%h so=%b busy=%b done=%b",
                 i, obs_q, obs_so, obs_busy, obs_done, e.q, e.so, e.busy, e.done);
      else n_pass++;
    end
    n_checks++; if (obs_q !== 8'h81) $display("FAIL b2b_final got %h want 81", obs_q); else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] qf;
    sel = 1'b1;
    set_in(1, 8'h96, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    set_in(0, 8'h00, 2'b01, 0, 1, 4'd5, 2'b00);
    tick();
    n_checks++; if (obs_busy !== 1'b1) $display("FAIL abort_busy got %b want 1", obs_busy); else n_pass++;
    set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    n_checks++; if (obs_q !== 8'hE5 || obs_busy !== 1'b1) $display("FAIL abort_shift1 got q=%h busy=%b want e5 1", obs_q, obs_busy); else n_pass++;
    set_in(1, 8'h5A, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    n_checks++; if (obs_q !== 8'h5A || obs_busy !== 1'b0 || obs_done !== 1'b0)
      $display("FAIL abort_load got q=%h busy=%b done=%b want 5a 0 0", obs_q, obs_busy, obs_done); else n_pass++;
    set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    n_checks++; if (obs_q !== 8'h5A || obs_busy !== 1'b0 || obs_done !== 1'b0)
      $display("FAIL abort_after got q=%h busy=%b done=%b want 5a 0 0", obs_q, obs_busy, obs_done); else n_pass++;
    // Asynchronous reset in the middle of a burst
    set_in(0, 8'h00, 2'b01, 0, 1, 4'd4, 2'b00);
    tick();
    set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (obs_q !== 8'h00 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_so !== 2'b00)
      $display("FAIL rst_mid got q=%h busy=%b done=%b so=%b want 00 0 0 00", obs_q, obs_busy, obs_done, obs_so); else n_pass++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (obs_done !== 1'b0 || obs_busy !== 1'b0 || obs_q !== 8'h00)
        $display("FAIL rst_quiet[%0d] got q=%h busy=%b done=%b want 00 0 0", i, obs_q, obs_busy, obs_done); else n_pass++;
    end
    set_in(1, 8'h96, 2'b00, 0, 0, 4'd0, 2'b00);
    tick();
    push_burst(8'h96, 2'b01, 2'b00, 3, 2, 1'b1, qf);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) set_in(0, 8'h00, 2'b01, 0, 1, 4'd3, 2'b00);
      else        set_in(0, 8'h00, 2'b00, 0, 0, 4'd0, 2'b00);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs_q !== e.q || obs_busy !== e.busy || obs_done !== e.done || (e.chk_so && obs_so !== e.so))
        $display("FAIL post_rst_burst[%0d] got q=%h so=%b busy=%b done=%b want q=%h so=%b busy=%b done=%b",
                 i, obs_q, obs_so, obs_busy, obs_done, e.q, e.so, e.busy, e.done);
      else n_pass++;
    end
    n_checks++; if (obs_q !== 8'hFE || obs_so !== 2'b01) $display("FAIL post_rst_final got q=%h so=%b want fe 01", obs_q, obs_so); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lsr_step();
    test_asr_burst();
    test_ror_lsl();
    test_count_zero();
    test_run_ignores();
    test_back_to_back();
    test_abort();
    n_checks++; if (sb.size() != 0) $display("FAIL scoreboard_left got %0d entries want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
